// File: rtl/control_sequencer.sv
// Microcoded control sequencer: fetch/decode microsteps, IR and RUN/HALT FSM.
// Define CTRL_SEQ_COND_JUMP_EN to enable the JC/JZ conditional jumps.
module control_sequencer #(
    parameter int DATA_WIDTH   = 8,
    parameter int OPCODE_WIDTH = 4,
    parameter int STEPS        = 5
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             step_en,
    input  logic                             resume,
    input  logic [DATA_WIDTH-1:0]            bus_in,
    input  logic                             carry_flag,
    input  logic                             zero_flag,
    output logic [15:0]                      ctrl,
    output logic [DATA_WIDTH-OPCODE_WIDTH-1:0] operand,
    output logic [3:0]                       step,
    output logic                             halted
);

    localparam logic [15:0] C_HLT = 16'h0001;
    localparam logic [15:0] C_MI  = 16'h0002;
    localparam logic [15:0] C_RI  = 16'h0004;
    localparam logic [15:0] C_RO  = 16'h0008;
    localparam logic [15:0] C_IO  = 16'h0010;
    localparam logic [15:0] C_II  = 16'h0020;
    localparam logic [15:0] C_AI  = 16'h0040;
    localparam logic [15:0] C_AO  = 16'h0080;
    localparam logic [15:0] C_EO  = 16'h0100;
    localparam logic [15:0] C_SU  = 16'h0200;
    localparam logic [15:0] C_BI  = 16'h0400;
    localparam logic [15:0] C_OI  = 16'h0800;
    localparam logic [15:0] C_CE  = 16'h1000;
    localparam logic [15:0] C_CO  = 16'h2000;
    localparam logic [15:0] C_J   = 16'h4000;
    localparam logic [15:0] C_FI  = 16'h8000;

    localparam logic [3:0] C_LAST = 4'(STEPS - 1);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [3:0]              r_step;
    logic [3:0]              w_step_nxt;
    logic [DATA_WIDTH-1:0]   r_ir;
    logic [DATA_WIDTH-1:0]   w_ir_nxt;
    logic [OPCODE_WIDTH-1:0] w_opcode;
    logic [15:0]             w_ctrl;
    logic [15:0]             w_exec;
    logic                    w_jc;
    logic                    w_jz;

    assign w_opcode = r_ir[DATA_WIDTH-1 -: OPCODE_WIDTH];

`ifdef CTRL_SEQ_COND_JUMP_EN
    assign w_jc = carry_flag;
    assign w_jz = zero_flag;
`else
    // Without conditional jumps, JC/JZ never take and act as NOPs.
    assign w_jc = 1'b0;
    assign w_jz = 1'b0;
    logic w_unused_flags;
    assign w_unused_flags = carry_flag ^ zero_flag;
`endif

    // Execute-phase microcode for steps 2..4.
    always_comb begin
        w_exec = '0;
        case (w_opcode)
            4'd1: begin
                case (r_step)
                    4'd2:    w_exec = C_IO | C_MI;
                    4'd3:    w_exec = C_RO | C_AI;
                    default: w_exec = '0;
                endcase
            end
            4'd2, 4'd3: begin
                case (r_step)
                    4'd2:    w_exec = C_IO | C_MI;
                    4'd3:    w_exec = C_RO | C_BI;
                    4'd4:    w_exec = C_EO | C_AI | C_FI
                                    | ((w_opcode == 4'd3) ? C_SU : 16'h0);
                    default: w_exec = '0;
                endcase
            end
            4'd4: begin
                case (r_step)
                    4'd2:    w_exec = C_IO | C_MI;
                    4'd3:    w_exec = C_AO | C_RI;
                    default: w_exec = '0;
                endcase
            end
            4'd5:  w_exec = (r_step == 4'd2) ? (C_IO | C_AI) : 16'h0;
            4'd6:  w_exec = (r_step == 4'd2) ? (C_IO | C_J) : 16'h0;
            4'd7:  w_exec = (r_step == 4'd2 && w_jc) ? (C_IO | C_J) : 16'h0;
            4'd8:  w_exec = (r_step == 4'd2 && w_jz) ? (C_IO | C_J) : 16'h0;
            4'd14: w_exec = (r_step == 4'd2) ? (C_AO | C_OI) : 16'h0;
            4'd15: w_exec = (r_step == 4'd2) ? C_HLT : 16'h0;
            default: w_exec = '0;
        endcase
    end

    always_comb begin
        w_ctrl = '0;
        if (r_state == S_HALT) begin
            w_ctrl = C_HLT;
        end else begin
            case (r_step)
                4'd0:             w_ctrl = C_CO | C_MI;
                4'd1:             w_ctrl = C_RO | C_II | C_CE;
                4'd2, 4'd3, 4'd4: w_ctrl = w_exec;
                default:          w_ctrl = '0;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_ir_nxt    = r_ir;
        case (r_state)
            S_RUN: begin
                if (step_en) begin
                    if (w_ctrl[0]) begin
                        w_state_nxt = S_HALT;
                    end else if (r_step >= 4'd2 && w_ctrl == 16'h0) begin
                        w_step_nxt = 4'd0;
                    end else if (r_step == C_LAST) begin
                        w_step_nxt = 4'd0;
                    end else begin
                        w_step_nxt = r_step + 4'd1;
                    end
                    if ((w_ctrl & C_II) != 16'h0) begin
                        w_ir_nxt = bus_in;
                    end
                end
            end
            S_HALT: begin
                // resume outranks step_en; the step stays frozen until then.
                if (resume) begin
                    w_state_nxt = S_RUN;
                    w_step_nxt  = 4'd0;
                end
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
            r_step  <= 4'd0;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_ir    <= w_ir_nxt;
        end
    end

    assign ctrl    = w_ctrl;
    assign operand = r_ir[DATA_WIDTH-OPCODE_WIDTH-1:0];
    assign step    = r_step;
    assign halted  = (r_state == S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: directed instruction streams.
// Honours CTRL_SEQ_COND_JUMP_EN for the conditional-jump expectations.
module tb_control_sequencer;

  logic        clk;
  logic        rst_n;
  logic        step_en;
  logic        resume;
  logic [7:0]  bus_in;
  logic        carry_flag;
  logic        zero_flag;
  logic [15:0] ctrl;
  logic [3:0]  operand;
  logic [3:0]  step;
  logic        halted;

  typedef struct {
    string       name;
    logic [15:0] ctrl;
    logic [3:0]  step;
    logic        halted;
    logic [3:0]  operand;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 0;

  control_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .step_en    (step_en),
    .resume     (resume),
    .bus_in     (bus_in),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .ctrl       (ctrl),
    .operand    (operand),
    .step       (step),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (ctrl !== e.ctrl || step !== e.step ||
          halted !== e.halted ||
          operand !== e.operand) begin
        errors++;
        $display("FAIL %s: got ctrl=%h step=%0d halted=%b op=%h, want ctrl=%h step=%0d halted=%b op=%h",
                 e.name, ctrl, step, halted, operand,
                 e.ctrl, e.step, e.halted, e.operand);
      end
    end
  end

  task automatic expect_out(input string n,
                            input logic [15:0] c,
                            input logic [3:0] s,
                            input logic h,
                            input logic [3:0] op);
    exp_t e;
    e.name    = n;
    e.ctrl    = c;
    e.step    = s;
    e.halted  = h;
    e.operand = op;
    q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic tick();
    step_en = 1'b1;
    @(posedge clk);
    #1;
    step_en = 1'b0;
  endtask

  task automatic fetch(input logic [7:0] ir);
    bus_in = ir;
    tick();
    tick();
  endtask

`ifdef CTRL_SEQ_COND_JUMP_EN
  localparam logic [15:0] JTAKEN = 16'h4010;
`else
  localparam logic [15:0] JTAKEN = 16'h0000;
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n      = 1'b0;
    step_en    = 1'b0;
    resume     = 1'b0;
    bus_in     = 8'h1E;
    carry_flag = 1'b0;
    zero_flag  = 1'b0;
    #1;
    checks++;
    if (ctrl !== 16'h2002 || step !== 4'd0 ||
        halted !== 1'b0 || operand !== 4'h0) begin
      errors++;
      $display("FAIL rst_imm: got ctrl=%h step=%0d halted=%b op=%h, want ctrl=2002 step=0 halted=0 op=0",
               ctrl, step, halted, operand);
    end
    expect_out("reset", 16'h2002, 4'd0, 1'b0, 4'h0);
    rst_n = 1'b1;

    tick();
    expect_out("fetch1", 16'h1028, 4'd1, 1'b0, 4'h0);
    tick();
    checks++;
    if (operand !== 4'hE) begin
      errors++;
      $display("FAIL ir_load: got op=%h, want op=e", operand);
    end
    expect_out("lda_s2", 16'h0012, 4'd2, 1'b0, 4'hE);
    tick();
    expect_out("lda_s3", 16'h0048, 4'd3, 1'b0, 4'hE);
    tick();
    expect_out("lda_s4", 16'h0000, 4'd4, 1'b0, 4'hE);
    tick();
    expect_out("lda_end", 16'h2002, 4'd0, 1'b0, 4'hE);

    fetch(8'h2F);
    expect_out("add_s2", 16'h0012, 4'd2, 1'b0, 4'hF);
    tick();
    expect_out("add_s3", 16'h0408, 4'd3, 1'b0, 4'hF);
    tick();
    expect_out("add_s4", 16'h8140, 4'd4, 1'b0, 4'hF);
    tick();
    expect_out("add_wrap", 16'h2002, 4'd0, 1'b0, 4'hF);

    fetch(8'h35);
    tick();
    tick();
    expect_out("sub_s4", 16'h8340, 4'd4, 1'b0, 4'h5);
    tick();

    fetch(8'h53);
    expect_out("ldi_s2", 16'h0050, 4'd2, 1'b0, 4'h3);
    tick();
    expect_out("ldi_s3", 16'h0000, 4'd3, 1'b0, 4'h3);
    tick();
    expect_out("ldi_end", 16'h2002, 4'd0, 1'b0, 4'h3);

    fetch(8'h74);
    carry_flag = 1'b1;
    expect_out("jc_c1", JTAKEN, 4'd2, 1'b0, 4'h4);
    carry_flag = 1'b0;
    expect_out("jc_c0", 16'h0000, 4'd2, 1'b0, 4'h4);
    tick();
    expect_out("jc_end", 16'h2002, 4'd0, 1'b0, 4'h4);
    fetch(8'h86);
    zero_flag = 1'b1;
    expect_out("jz_z1", JTAKEN, 4'd2, 1'b0, 4'h6);
    zero_flag = 1'b0;
    expect_out("jz_z0", 16'h0000, 4'd2, 1'b0, 4'h6);
    tick();

    resume = 1'b1;
    tick();
    resume = 1'b0;
    expect_out("resume_run", 16'h1028, 4'd1, 1'b0, 4'h6);
    bus_in = 8'hF0;
    tick();
    expect_out("hlt_s2", 16'h0001, 4'd2, 1'b0, 4'h0);
    tick();
    expect_out("halt_enter", 16'h0001, 4'd2, 1'b1, 4'h0);
    bus_in = 8'h2A;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("halt_hold", 16'h0001, 4'd2, 1'b1, 4'h0);
    end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    expect_out("resume", 16'h2002, 4'd0, 1'b0, 4'h0);

    fetch(8'h4A);
    expect_out("sta_s2", 16'h0012, 4'd2, 1'b0, 4'hA);
    tick();
    expect_out("sta_s3", 16'h0084, 4'd3, 1'b0, 4'hA);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ctrl !== 16'h2002 || step !== 4'd0) begin
      errors++;
      $display("FAIL async_imm: got ctrl=%h step=%0d, want ctrl=2002 step=0",
               ctrl, step);
    end
    expect_out("async_rst", 16'h2002, 4'd0, 1'b0, 4'h0);
    rst_n = 1'b1;
    bus_in = 8'h1C;
    tick();
    expect_out("post_rst", 16'h1028, 4'd1, 1'b0, 4'h0);

    done = 1'b1;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    if (errors != 0) begin
      $display("FAIL summary: got %0d errors, want 0", errors);
    end else begin
      $display("PASS");
    end
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, shall set the bus and instruction register width.
REQ-002 Parameter OPCODE_WIDTH, default 4, shall set the opcode field (IR upper bits); DATA_WIDTH > OPCODE_WIDTH, with OPCODE_WIDTH fixed at 4 for the opcode table.
REQ-003 Parameter STEPS, default 5, legal 5..16, shall set microsteps per instruction.
REQ-004 Port clk, input, 1, shall be the single system clock.
REQ-005 Port rst_n, input, 1, shall be the asynchronous active-low reset.
REQ-006 Port step_en, input, 1, shall be the one-clk advance tick; all state changes qualify on it, except resume and reset.
REQ-007 Port resume, input, 1, shall return the block from HALT to RUN.
REQ-008 Port bus_in, input, DATA_WIDTH, shall carry the main bus value.
REQ-009 Ports carry_flag and zero_flag, input, 1 each, shall carry the latched ALU flags.
REQ-010 Port ctrl, output, 16, shall be the control word: bit 0 HLT, 1 MI, 2 RI, 3 RO, 4 IO, 5 II, 6 AI, 7 AO, 8 EO, 9 SU, 10 BI, 11 OI, 12 CE, 13 CO, 14 J, 15 FI.
REQ-011 Port operand, output, DATA_WIDTH-OPCODE_WIDTH, shall carry the IR lower bits; the enclosing design drives it onto the bus under IO.
REQ-012 Port step, output, 4, shall carry the current microstep.
REQ-013 Port halted, output, 1, shall be high in HALT.

Function
REQ-014 ctrl shall be combinational from the step, the IR opcode, the flags and the state.
REQ-015 Step 0 shall output CO|MI, and step 1 shall output RO|II|CE, for every opcode.
REQ-016 IR shall load bus_in on a clk edge where step_en=1 and II is active.
REQ-017 Steps 2..4 shall decode per opcode:
- 1 LDA: IO|MI, RO|AI
- 2 ADD: IO|MI, RO|BI, EO|AI|FI
- 3 SUB: as ADD, with SU added in step 4
- 4 STA: IO|MI, AO|RI
- 5 LDI: IO|AI
- 6 JMP: IO|J
- 7 JC: IO|J if carry_flag, else 0
- 8 JZ: IO|J if zero_flag, else 0
- 14 OUT: AO|OI
- 15 HLT: HLT
- all others: 0
REQ-018 Any step >= 5 shall decode to 0.
REQ-019 With step_en=1, step shall advance by 1, wrapping STEPS-1 -> 0.
REQ-020 Early end: with step >= 2 and a decoded word of 0, step_en shall force step to 0.
REQ-021 FSM states shall be RUN and HALT; RUN -> HALT when step_en=1 and ctrl bit HLT=1.
REQ-022 In HALT, ctrl shall equal 0x0001, step and IR shall freeze, and step_en shall be ignored.
REQ-023 resume=1 in HALT shall enter RUN with step=0 on the next edge; resume in RUN shall have no effect.
REQ-024 When resume and step_en are both high in HALT, resume shall win and the step shall not advance.

Reset
REQ-025 rst_n low shall immediately force step=0, IR=0, state RUN, halted=0, ctrl=0x2002 and operand=0, independent of clk.
REQ-026 Reset asserted mid-instruction shall abandon the instruction, and execution shall restart at fetch step 0 after release.

Configuration
REQ-027 Macro CTRL_SEQ_COND_JUMP_EN defined shall implement JC/JZ per REQ-017.
REQ-028 Macro CTRL_SEQ_COND_JUMP_EN undefined shall decode opcodes 7/8 as NOP, and carry_flag and zero_flag shall be unused.

Verification
REQ-029 Reset then 2 ticks with bus_in=0x1E -> ctrl 0x2002, 0x1028; IR=0x1E; operand=0xE.
REQ-030 IR=0x2F (ADD), ticks through steps 2..4 -> ctrl 0x0012, 0x0408, 0x8140; step then returns 0.
REQ-031 IR=0x53 (LDI) -> step 2 ctrl 0x0050, step 3 ctrl 0x0000, next tick step=0 (early end).
REQ-032 IR=0xF0 at step 2, one tick -> halted=1, ctrl=0x0001; 3 more ticks with no change; resume=1 with step_en=1 -> RUN, step=0.
REQ-033 Macro defined, IR=0x74 -> step 2 ctrl 0x4010 with carry_flag=1 and 0x0000 with carry_flag=0; macro undefined -> 0x0000 for both.
REQ-034 rst_n low at step 3 of STA with no clk edge -> step=0 and ctrl=0x2002 immediately.
